// File: rtl/adder_chk_pkg.sv
// Shared types and reference model for the adder response checker.
// State encoding, default widths and the expected-sum function.
package adder_chk_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Zero-extended sum, one bit wider than the operands.
    function automatic logic [WIDTH_DEF:0] exp_sum(
        input logic [WIDTH_DEF-1:0] a,
        input logic [WIDTH_DEF-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_chk_stage.sv
// Compare stage: registers one accepted (a,b,sum) and checks it.
// Ports: load_i/a_i/b_i/sum_i in; valid_o, pass_o/fail_o pulses, captured fields out.
module adder_chk_stage
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH:0]   sum_i,
    output logic             valid_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH:0]   sum_o,
    output logic [WIDTH:0]   exp_o
);

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                sum_q <= sum_i;
            end
        end
    end

    assign exp_o   = {1'b0, a_q} + {1'b0, b_q};
    assign valid_o = valid_q;
    assign pass_o  = valid_q && (sum_q == exp_o);
    assign fail_o  = valid_q && (sum_q != exp_o);
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for the adder: accepts (a,b,sum) over valid/ready,
// counts pass/fail and captures the first mismatch. Ports per block header.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_txn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH:0]   err_sum,
    output logic [WIDTH:0]   err_exp
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ea_q, ea_d;
    logic [WIDTH-1:0] eb_q, eb_d;
    logic [WIDTH:0]   es_q, es_d;
    logic [WIDTH:0]   ee_q, ee_d;

    logic             accept;
    logic             stg_valid;
    logic             stg_pass;
    logic             stg_fail;
    logic [WIDTH-1:0] stg_a;
    logic [WIDTH-1:0] stg_b;
    logic [WIDTH:0]   stg_sum;
    logic [WIDTH:0]   stg_exp;

    // Ready comes only from registered state, never from in_valid.
    assign in_ready = (state_q == RUN) && (rem_q != '0);
    assign accept   = in_valid && in_ready;

    adder_chk_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .a_i     (in_a),
        .b_i     (in_b),
        .sum_i   (in_sum),
        .valid_o (stg_valid),
        .pass_o  (stg_pass),
        .fail_o  (stg_fail),
        .a_o     (stg_a),
        .b_o     (stg_b),
        .sum_o   (stg_sum),
        .exp_o   (stg_exp)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        es_d    = es_q;
        ee_d    = ee_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    rem_d   = num_txn;
                    pass_d  = '0;
                    fail_d  = '0;
                    err_d   = 1'b0;
                    ea_d    = '0;
                    eb_d    = '0;
                    es_d    = '0;
                    ee_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                if (stg_pass && (pass_q != CNT_MAX)) begin
                    pass_d = pass_q + CNT_W'(1);
                end
                if (stg_fail) begin
                    if (fail_q != CNT_MAX) begin
                        fail_d = fail_q + CNT_W'(1);
                    end
                    // Only the first mismatch of a run is kept.
                    if (!err_q) begin
                        err_d = 1'b1;
                        ea_d  = stg_a;
                        eb_d  = stg_b;
                        es_d  = stg_sum;
                        ee_d  = stg_exp;
                    end
                end
                // Finish only once the last compare has retired.
                if ((rem_q == '0) && !stg_valid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            es_q    <= '0;
            ee_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            es_q    <= es_d;
            ee_q    <= ee_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign err_a    = ea_q;
    assign err_b    = eb_q;
    assign err_sum  = es_q;
    assign err_exp  = ee_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker (CNT_W=16 and CNT_W=2 instances).
// Stimulus shared by both; each check compares against hand-computed values.
module tb_adder_resp_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_txn;
    logic        in_valid;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [4:0]  in_sum;

    logic        rdy, busy, done, err;
    logic [15:0] pass_cnt, fail_cnt;
    logic [3:0]  err_a, err_b;
    logic [4:0]  err_sum, err_exp;

    logic        rdy2, busy2, done2, err2;
    logic [1:0]  pass2, fail2;
    logic [3:0]  err_a2, err_b2;
    logic [4:0]  err_sum2, err_exp2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_resp_checker #(.WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn),
        .in_valid(in_valid), .in_ready(rdy),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err),
        .err_a(err_a), .err_b(err_b),
        .err_sum(err_sum), .err_exp(err_exp)
    );

    adder_resp_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn[1:0]),
        .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .busy(busy2), .done(done2),
        .pass_cnt(pass2), .fail_cnt(fail2), .err(err2),
        .err_a(err_a2), .err_b(err_b2),
        .err_sum(err_sum2), .err_exp(err_exp2)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sum   = s;
    endtask

    task automatic kick(input logic [15:0] n);
        start   = 1'b1;
        num_txn = n;
        step();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_txn = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", rdy, 0);
        check("rst_cnt", {pass_cnt, fail_cnt}, 0);
        check("rst_err", {err, err_a, err_b, err_sum, err_exp}, 0);

        // Run 1: three matching beats back-to-back.
        kick(16'd3);
        check("r1_busy", busy, 1);
        check("r1_rdy", rdy, 1);
        beat(4'd3, 4'd2, 5'd5);   step();
        check("r1_pass_lat", pass_cnt, 0);
        beat(4'd7, 4'd8, 5'd15);  step();
        check("r1_pass_one", pass_cnt, 1);
        beat(4'd15, 4'd15, 5'd30); step();
        in_valid = 1'b0;
        check("r1_rdy_low", rdy, 0);
        check("r1_pass_two", pass_cnt, 2);
        step();
        check("r1_done_early", done, 0);
        check("r1_pass", pass_cnt, 3);
        step();
        check("r1_done", done, 1);
        check("r1_busy_low", busy, 0);
        check("r1_fail", fail_cnt, 0);
        check("r1_err", err, 0);

        // Run 2: two mismatches; the first one is captured.
        kick(16'd2);
        check("r2_clear", pass_cnt, 0);
        beat(4'd15, 4'd15, 5'd29); step();
        beat(4'd1, 4'd1, 5'd3);    step();
        in_valid = 1'b0;
        step();
        step();
        check("r2_done", done, 1);
        check("r2_fail", fail_cnt, 2);
        check("r2_pass", pass_cnt, 0);
        check("r2_err", err, 1);
        check("r2_err_a", err_a, 15);
        check("r2_err_b", err_b, 15);
        check("r2_err_sum", err_sum, 29);
        check("r2_err_exp", err_exp, 30);

        // Run 3: empty budget.
        kick(16'd0);
        check("r3_busy", busy, 1);
        check("r3_rdy", rdy, 0);
        check("r3_cnt", {pass_cnt, fail_cnt, 15'd0, err}, 0);
        step();
        check("r3_done", done, 1);
        check("r3_rdy_end", rdy, 0);

        // Run 4: gapped beats, fifth offered beyond the budget.
        kick(16'd4);
        for (int i = 0; i < 5; i++) begin
            beat(4'(i), 4'd1, 5'(i + 1));
            step();
            in_valid = 1'b0;
            repeat ((i % 3) + 1) step();
        end
        step();
        check("r4_pass", pass_cnt, 4);
        check("r4_fail", fail_cnt, 0);
        check("r4_done", done, 1);
        check("r4_rdy", rdy, 0);

        // Run 5: narrow counters, three fails then three passes.
        kick(16'd3);
        for (int i = 0; i < 3; i++) begin
            beat(4'd1, 4'd1, 5'd0);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("r5_fail2", fail2, 3);
        check("r5_err2", err2, 1);
        check("r5_exp2", err_exp2, 2);
        check("r5_done2", done2, 1);
        kick(16'd3);
        check("r5_clear2", {pass2, fail2, err2}, 0);
        for (int i = 0; i < 3; i++) begin
            beat(4'd9, 4'd9, 5'd18);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("r5_pass2", pass2, 3);
        check("r5_fail2b", fail2, 0);
        check("r5_pass_w", pass_cnt, 3);

        // Run 6: reset after two of five accepts.
        kick(16'd5);
        beat(4'd2, 4'd2, 5'd4); step();
        beat(4'd2, 4'd3, 5'd4); step();
        check("r6_pre", pass_cnt, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        check("r6_busy", busy, 0);
        check("r6_rdy", rdy, 0);
        check("r6_outs", {done, err, pass_cnt, fail_cnt}, 0);
        check("r6_errf", {err_a, err_b, err_sum, err_exp}, 0);
        rst = 1'b0;
        step();
        check("r6_stay", {busy, done, pass_cnt, fail_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
